// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory
// and loads the IF/ID register. Define FETCH_HLT_DETECT_EN to stop fetching on HLT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        PCDisrupt,
  input  logic [15:0] PCBranch,
  output logic        IMem_Req,
  output logic [15:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [15:0] IMem_Data,
  output logic [15:0] IFID_Instruction,
  output logic [15:0] IFID_PC,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [15:0] Fetch_Count,
  output logic [1:0]  dbg_state
);

  // Memory handshake: a request is presented while IMem_Req=1 with IMem_Addr
  // held constant; it completes on the first rising edge where IMem_Ack=1, and
  // IMem_Data is only meaningful in that cycle. There is no back-pressure on
  // the response side.

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_SQUASH = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] redir_q, redir_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] count_q, count_d;
  logic        deliver;
  logic [15:0] deliver_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      hold_q    <= 16'h0000;
      redir_q   <= 16'h0000;
      instr_q   <= 16'h0000;
      ifid_pc_q <= 16'h0000;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      redir_q   <= redir_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    redir_d      = redir_q;
    instr_d      = instr_q;
    ifid_pc_d    = ifid_pc_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    count_d      = count_q;
    deliver      = 1'b0;
    deliver_word = IMem_Data;

    case (state_q)
      S_FETCH: begin
        if (PCDisrupt) begin
          valid_d = 1'b0;
          if (IMem_Ack) begin
            pc_d = PCBranch;
          end else begin
            // The in-flight request cannot be withdrawn; remember the target.
            redir_d = PCBranch;
            state_d = S_SQUASH;
          end
        end else if (Stall) begin
          if (IMem_Ack) begin
            hold_d  = IMem_Data;
            state_d = S_HOLD;
          end
        end else if (IMem_Ack) begin
          deliver      = 1'b1;
          deliver_word = IMem_Data;
        end else begin
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (PCDisrupt) begin
          pc_d    = PCBranch;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (!Stall) begin
          deliver      = 1'b1;
          deliver_word = hold_q;
          state_d      = S_FETCH;
        end
      end
      S_SQUASH: begin
        valid_d = 1'b0;
        if (IMem_Ack) begin
          pc_d    = PCDisrupt ? PCBranch : redir_q;
          state_d = S_FETCH;
        end else if (PCDisrupt) begin
          redir_d = PCBranch;
        end
      end
      S_HALT: begin
        if (PCDisrupt) begin
          halted_d = 1'b0;
          pc_d     = PCBranch;
          valid_d  = 1'b0;
          state_d  = S_FETCH;
        end else if (!Stall) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (deliver) begin
      instr_d   = deliver_word;
      ifid_pc_d = pc_q;
      valid_d   = 1'b1;
      count_d   = count_q + 16'd1;
`ifdef FETCH_HLT_DETECT_EN
      // HLT leaves the PC pointing at itself so a restart is unambiguous.
      if (deliver_word[15:12] == 4'hF) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end else begin
        pc_d = pc_q + 16'd2;
      end
`else
      pc_d = pc_q + 16'd2;
`endif
    end
  end

  assign IMem_Req         = rst && ((state_q == S_FETCH) || (state_q == S_SQUASH));
  assign IMem_Addr        = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PC          = ifid_pc_q;
  assign IFID_Valid       = valid_q;
  assign Halted           = halted_q;
  assign Fetch_Count      = count_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns fixed words per address,
// ack/stall/redirect are driven per cycle from tasks on the falling edge.
module tb_fetch_unit;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        PCDisrupt;
  logic [15:0] PCBranch;
  logic        IMem_Req;
  logic [15:0] IMem_Addr;
  logic        IMem_Ack;
  logic [15:0] IMem_Data;
  logic [15:0] IFID_Instruction;
  logic [15:0] IFID_PC;
  logic        IFID_Valid;
  logic        Halted;
  logic [15:0] Fetch_Count;
  logic [1:0]  dbg_state;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .PCDisrupt(PCDisrupt), .PCBranch(PCBranch),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data),
    .IFID_Instruction(IFID_Instruction), .IFID_PC(IFID_PC), .IFID_Valid(IFID_Valid),
    .Halted(Halted), .Fetch_Count(Fetch_Count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a few fixed words, otherwise 3xxx tagged by address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1123;
      16'h0002: return 16'h2456;
      16'h000A: return 16'hF000;
      default:  return {4'h3, a[11:0]};
    endcase
  endfunction

  assign IMem_Data = mem_word(IMem_Addr);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; Stall = 1'b0; PCDisrupt = 1'b0; PCBranch = 16'h0000; IMem_Ack = 1'b0;
    repeat (2) @(negedge clk);
    exp_count = 16'h0000;
    checks++; if (IMem_Req !== 1'b0) begin failures++; $display("FAIL reset_req got=%h exp=0", IMem_Req); end
    checks++; if (IMem_Addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", IMem_Addr); end
    checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", IFID_Valid); end
    checks++; if (IFID_Instruction !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", IFID_PC); end
    checks++; if (Halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%h exp=0", Halted); end
    checks++; if (Fetch_Count !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h exp=0000", Fetch_Count); end
    checks++; if (dbg_state !== ST_FETCH) begin failures++; $display("FAIL reset_state got=%h exp=%h", dbg_state, ST_FETCH); end
  endtask

  task automatic test_zero_wait();
    rst = 1'b1; IMem_Ack = 1'b1;
    #1;
    checks++; if (IMem_Req !== 1'b1) begin failures++; $display("FAIL zw_req got=%h exp=1", IMem_Req); end
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'h1123) begin failures++; $display("FAIL zw_instr0 got=%h exp=1123", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h0000) begin failures++; $display("FAIL zw_pc0 got=%h exp=0000", IFID_PC); end
    checks++; if (IFID_Valid !== 1'b1) begin failures++; $display("FAIL zw_valid0 got=%h exp=1", IFID_Valid); end
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'h2456) begin failures++; $display("FAIL zw_instr1 got=%h exp=2456", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h0002) begin failures++; $display("FAIL zw_pc1 got=%h exp=0002", IFID_PC); end
    checks++; if (Fetch_Count !== exp_count) begin failures++; $display("FAIL zw_count got=%h exp=%h", Fetch_Count, exp_count); end
    IMem_Ack = 1'b0;
  endtask

  task automatic test_stall_hold();
    checks++; if (IMem_Addr !== 16'h0004) begin failures++; $display("FAIL hold_addr0 got=%h exp=0004", IMem_Addr); end
    IMem_Ack = 1'b1; Stall = 1'b1;
    tick();
    checks++; if (dbg_state !== ST_HOLD) begin failures++; $display("FAIL hold_state got=%h exp=%h", dbg_state, ST_HOLD); end
    checks++; if (IMem_Req !== 1'b0) begin failures++; $display("FAIL hold_req got=%h exp=0", IMem_Req); end
    checks++; if (IFID_Instruction !== 16'h2456) begin failures++; $display("FAIL hold_frozen_instr got=%h exp=2456", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h0002) begin failures++; $display("FAIL hold_frozen_pc got=%h exp=0002", IFID_PC); end
    IMem_Ack = 1'b0;
    tick();
    checks++; if (dbg_state !== ST_HOLD) begin failures++; $display("FAIL hold_state2 got=%h exp=%h", dbg_state, ST_HOLD); end
    checks++; if (IFID_Instruction !== 16'h2456) begin failures++; $display("FAIL hold_frozen2 got=%h exp=2456", IFID_Instruction); end
    Stall = 1'b0;
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'h3004) begin failures++; $display("FAIL hold_release_instr got=%h exp=3004", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h0004) begin failures++; $display("FAIL hold_release_pc got=%h exp=0004", IFID_PC); end
    checks++; if (IFID_Valid !== 1'b1) begin failures++; $display("FAIL hold_release_valid got=%h exp=1", IFID_Valid); end
    checks++; if (IMem_Addr !== 16'h0006) begin failures++; $display("FAIL hold_next_addr got=%h exp=0006", IMem_Addr); end
    checks++; if (Fetch_Count !== exp_count) begin failures++; $display("FAIL hold_count got=%h exp=%h", Fetch_Count, exp_count); end
  endtask

  task automatic test_ack_delay();
    IMem_Ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (IMem_Addr !== 16'h0006) begin failures++; $display("FAIL delay_addr[%0d] got=%h exp=0006", i, IMem_Addr); end
      checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL delay_bubble[%0d] got=%h exp=0", i, IFID_Valid); end
      checks++; if (IMem_Req !== 1'b1) begin failures++; $display("FAIL delay_req[%0d] got=%h exp=1", i, IMem_Req); end
    end
    IMem_Ack = 1'b1;
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'h3006) begin failures++; $display("FAIL delay_instr got=%h exp=3006", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h0006) begin failures++; $display("FAIL delay_pc got=%h exp=0006", IFID_PC); end
    checks++; if (IFID_Valid !== 1'b1) begin failures++; $display("FAIL delay_valid got=%h exp=1", IFID_Valid); end
    IMem_Ack = 1'b0;
  endtask

  task automatic test_redirect_squash();
    PCDisrupt = 1'b1; PCBranch = 16'h0040;
    tick();
    checks++; if (dbg_state !== ST_SQUASH) begin failures++; $display("FAIL sq_state got=%h exp=%h", dbg_state, ST_SQUASH); end
    checks++; if (IMem_Addr !== 16'h0008) begin failures++; $display("FAIL sq_addr_hold got=%h exp=0008", IMem_Addr); end
    checks++; if (IMem_Req !== 1'b1) begin failures++; $display("FAIL sq_req got=%h exp=1", IMem_Req); end
    checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL sq_bubble got=%h exp=0", IFID_Valid); end
    PCDisrupt = 1'b0; PCBranch = 16'h1234;
    tick();
    checks++; if (IMem_Addr !== 16'h0008) begin failures++; $display("FAIL sq_addr_wait got=%h exp=0008", IMem_Addr); end
    IMem_Ack = 1'b1;
    tick();
    checks++; if (IMem_Addr !== 16'h0040) begin failures++; $display("FAIL sq_target got=%h exp=0040", IMem_Addr); end
    checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL sq_discard got=%h exp=0", IFID_Valid); end
    checks++; if (Fetch_Count !== exp_count) begin failures++; $display("FAIL sq_count got=%h exp=%h", Fetch_Count, exp_count); end
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'h3040) begin failures++; $display("FAIL sq_first_instr got=%h exp=3040", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h0040) begin failures++; $display("FAIL sq_first_pc got=%h exp=0040", IFID_PC); end
    IMem_Ack = 1'b0;
  endtask

  task automatic test_redirect_ack_and_hold();
    IMem_Ack = 1'b1; PCDisrupt = 1'b1; PCBranch = 16'h0100;
    tick();
    checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL rda_bubble got=%h exp=0", IFID_Valid); end
    checks++; if (IMem_Addr !== 16'h0100) begin failures++; $display("FAIL rda_addr got=%h exp=0100", IMem_Addr); end
    checks++; if (Fetch_Count !== exp_count) begin failures++; $display("FAIL rda_count got=%h exp=%h", Fetch_Count, exp_count); end
    PCDisrupt = 1'b0;
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'h3100) begin failures++; $display("FAIL rda_instr got=%h exp=3100", IFID_Instruction); end
    Stall = 1'b1;
    tick();
    PCDisrupt = 1'b1; PCBranch = 16'h0200;
    tick();
    checks++; if (dbg_state !== ST_FETCH) begin failures++; $display("FAIL rdh_state got=%h exp=%h", dbg_state, ST_FETCH); end
    checks++; if (IMem_Addr !== 16'h0200) begin failures++; $display("FAIL rdh_addr got=%h exp=0200", IMem_Addr); end
    checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL rdh_bubble got=%h exp=0", IFID_Valid); end
    checks++; if (Fetch_Count !== exp_count) begin failures++; $display("FAIL rdh_count got=%h exp=%h", Fetch_Count, exp_count); end
    PCDisrupt = 1'b0; Stall = 1'b0; IMem_Ack = 1'b0;
  endtask

  task automatic test_hlt();
    IMem_Ack = 1'b1; PCDisrupt = 1'b1; PCBranch = 16'h000A;
    tick();
    PCDisrupt = 1'b0;
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'hF000) begin failures++; $display("FAIL hlt_instr got=%h exp=F000", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h000A) begin failures++; $display("FAIL hlt_pc got=%h exp=000A", IFID_PC); end
    checks++; if (IFID_Valid !== 1'b1) begin failures++; $display("FAIL hlt_valid got=%h exp=1", IFID_Valid); end
`ifdef FETCH_HLT_DETECT_EN
    checks++; if (Halted !== 1'b1) begin failures++; $display("FAIL hlt_halted got=%h exp=1", Halted); end
    checks++; if (dbg_state !== ST_HALT) begin failures++; $display("FAIL hlt_state got=%h exp=%h", dbg_state, ST_HALT); end
    checks++; if (IMem_Req !== 1'b0) begin failures++; $display("FAIL hlt_req got=%h exp=0", IMem_Req); end
    checks++; if (IMem_Addr !== 16'h000A) begin failures++; $display("FAIL hlt_frozen_pc got=%h exp=000A", IMem_Addr); end
    IMem_Ack = 1'b0;
    tick();
    checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL hlt_drain got=%h exp=0", IFID_Valid); end
    checks++; if (Halted !== 1'b1) begin failures++; $display("FAIL hlt_stay got=%h exp=1", Halted); end
    PCDisrupt = 1'b1; PCBranch = 16'h0020;
    tick();
    checks++; if (Halted !== 1'b0) begin failures++; $display("FAIL hlt_clear got=%h exp=0", Halted); end
    checks++; if (IMem_Addr !== 16'h0020) begin failures++; $display("FAIL hlt_restart_addr got=%h exp=0020", IMem_Addr); end
    checks++; if (IMem_Req !== 1'b1) begin failures++; $display("FAIL hlt_restart_req got=%h exp=1", IMem_Req); end
    PCDisrupt = 1'b0; IMem_Ack = 1'b1;
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'h3020) begin failures++; $display("FAIL hlt_restart_instr got=%h exp=3020", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'h0020) begin failures++; $display("FAIL hlt_restart_pc got=%h exp=0020", IFID_PC); end
`else
    checks++; if (Halted !== 1'b0) begin failures++; $display("FAIL hlt_off_halted got=%h exp=0", Halted); end
    checks++; if (IMem_Addr !== 16'h000C) begin failures++; $display("FAIL hlt_off_addr got=%h exp=000C", IMem_Addr); end
    checks++; if (dbg_state !== ST_FETCH) begin failures++; $display("FAIL hlt_off_state got=%h exp=%h", dbg_state, ST_FETCH); end
    checks++; if (IMem_Req !== 1'b1) begin failures++; $display("FAIL hlt_off_req got=%h exp=1", IMem_Req); end
`endif
    checks++; if (Fetch_Count !== exp_count) begin failures++; $display("FAIL hlt_count got=%h exp=%h", Fetch_Count, exp_count); end
    IMem_Ack = 1'b0;
  endtask

  task automatic test_pc_wrap();
    IMem_Ack = 1'b1; PCDisrupt = 1'b1; PCBranch = 16'hFFFE;
    tick();
    checks++; if (IMem_Addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_start got=%h exp=FFFE", IMem_Addr); end
    PCDisrupt = 1'b0;
    tick();
    exp_count = exp_count + 16'd1;
    checks++; if (IFID_Instruction !== 16'h3FFE) begin failures++; $display("FAIL wrap_instr got=%h exp=3FFE", IFID_Instruction); end
    checks++; if (IFID_PC !== 16'hFFFE) begin failures++; $display("FAIL wrap_pc got=%h exp=FFFE", IFID_PC); end
    checks++; if (IMem_Addr !== 16'h0000) begin failures++; $display("FAIL wrap_next got=%h exp=0000", IMem_Addr); end
    checks++; if (Fetch_Count !== exp_count) begin failures++; $display("FAIL wrap_count got=%h exp=%h", Fetch_Count, exp_count); end
    IMem_Ack = 1'b0;
  endtask

  task automatic test_reset_mid_request();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (IMem_Req !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%h exp=0", IMem_Req); end
    checks++; if (IMem_Addr !== 16'h0000) begin failures++; $display("FAIL rstmid_addr got=%h exp=0000", IMem_Addr); end
    checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%h exp=0", IFID_Valid); end
    checks++; if (Fetch_Count !== 16'h0000) begin failures++; $display("FAIL rstmid_count got=%h exp=0000", Fetch_Count); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_ack_delay();
    test_redirect_squash();
    test_redirect_ack_and_hold();
    test_hlt();
    test_pc_wrap();
    test_reset_mid_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the ID stage: owns the PC register, issues requests to instruction memory over a req/ack handshake, and drives the IF side of the IF/ID pipeline register (instruction, PC, valid). It obeys the ID stage's stall and PC-redirect outputs, squashes wrong-path fetches, and stops fetching on HLT.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `Stall`  in  1  freeze request from ID (`IF_Stall`).
- `PCDisrupt`  in  1  redirect request from ID (`IF_PCDisrupt`).
- `PCBranch`  in  16  redirect target (`IF_PCBranch`); sampled only when `PCDisrupt`=1.
- `IMem_Req`  out  1  fetch request to instruction memory.
- `IMem_Addr`  out  16  fetch address; equals current PC.
- `IMem_Ack`  in  1  memory response; `IMem_Data` is valid in any cycle where `IMem_Req`=1 and `IMem_Ack`=1.
- `IMem_Data`  in  16  fetched instruction word.
- `IFID_Instruction`  out  16  registered instruction to IF/ID.
- `IFID_PC`  out  16  registered address of `IFID_Instruction`.
- `IFID_Valid`  out  1  registered; 0 marks a bubble.
- `Halted`  out  1  registered; HLT fetched and fetch stopped.
- `Fetch_Count`  out  16  registered count of instructions delivered with `IFID_Valid`=1.

## Operation
- States: FETCH, HOLD, SQUASH, HALT. Internal registers: PC, hold buffer (16), redirect buffer (16).
- Reset values: state=FETCH, PC=`RESET_PC`, `IFID_Instruction`=16'h0000, `IFID_PC`=16'h0000, `IFID_Valid`=0, `Halted`=0, `Fetch_Count`=0. `IMem_Req`=0 while `rst`=0; reset mid-request abandons it with no further action.
- `IMem_Req`=1 only in FETCH and SQUASH. `IMem_Addr` is stable while `IMem_Req`=1 and not acked.
- Priority each cycle: `PCDisrupt` > `Stall` > normal flow.
- FETCH, ack, no Stall/Disrupt: output regs load {data, PC, Valid=1}; PC <= PC+2 (16-bit, wraps FFFE->0000); `Fetch_Count`++ (wraps).
- FETCH, ack, Stall: data captured in hold buffer; output regs unchanged; -> HOLD.
- FETCH, no ack, no Stall/Disrupt: `IFID_Valid` <= 0 (bubble). With Stall: output regs unchanged.
- HOLD: `IMem_Req`=0. When Stall drops: output regs load held word, Valid=1, PC <= PC+2, count++, -> FETCH.
- PCDisrupt in FETCH with ack same cycle, or in HOLD: data discarded, PC <= `PCBranch`, `IFID_Valid` <= 0, -> FETCH.
- PCDisrupt in FETCH without ack: `PCBranch` stored in redirect buffer; `IFID_Valid` <= 0; -> SQUASH.
- SQUASH: keeps old request until ack; ack data discarded; then PC <= redirect buffer, -> FETCH. A further PCDisrupt in SQUASH overwrites the redirect buffer. `IFID_Valid` stays 0.
- HALT: `IMem_Req`=0, `Halted`=1, PC frozen, `IFID_Valid` <= 0 once the HLT word leaves under no Stall. PCDisrupt: `Halted` <= 0, PC <= `PCBranch`, -> FETCH. This covers a wrong-path HLT that ID squashes.

## Timing
- IF/ID outputs change one cycle after the qualifying ack (or after the Stall release in HOLD).
- Zero-wait memory (ack in the same cycle as req) gives a throughput of one instruction per cycle.
- A redirect produces at least one bubble. The first target word appears one cycle after its ack.
- `Stall` and `PCDisrupt` are sampled at the same edge as `IMem_Ack`.

## Configuration
- `FETCH_HLT_DETECT_EN` defined: a word with opcode [15:12]=4'hF delivered to IF/ID (directly or from HOLD) does not advance PC. The state moves to HALT and `Halted` <= 1 on the same edge.
- Not defined: HLT is treated as an ordinary instruction. PC keeps advancing, HALT is unreachable, and `Halted` is tied to 0.

## Test plan
- Reset release, zero-wait memory returning 16'h1123 at 0x0000 and 16'h2456 at 0x0002: `IFID_Instruction`/`IFID_PC` show 1123/0000 then 2456/0002 on consecutive cycles; `Fetch_Count`=2.
- Ack delayed 3 cycles: `IMem_Addr` stays stable and `IFID_Valid`=0 for the 3 waiting cycles; the word is delivered the cycle after the ack.
- Ack at 0x0004 while `Stall`=1 for 2 cycles: output regs are frozen and state is HOLD with `IMem_Req`=0. The word appears with PC 0004 one cycle after Stall drops; next fetch is 0x0006.
- `PCDisrupt` with `PCBranch`=0x0040 during an outstanding fetch of 0x0008: the 0x0008 data is discarded after its ack, and the next request is 0x0040 with no valid output in between.
- With the macro defined, fetch of 16'hF000 at 0x000A: it is delivered, then `Halted`=1, `IMem_Req`=0, PC=0x000A. A later `PCDisrupt` to 0x0020 clears `Halted` and fetches 0x0020.
- PC wrap: start fetching at 0xFFFE, ack: next `IMem_Addr`=0x0000.
